// File: rtl/div_array_sched.sv
// Round-robin sequencer sharing one 16/8 combinational array divider between two requesters.
// Optional build macro DIV_OVF_CHECK_EN: flags overflow / divide-by-zero at accept and skips settling.
module div_array_sched #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_n,
  input  logic [7:0]  req0_d,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_n,
  input  logic [7:0]  req1_d,
  output logic [15:0] div_n,
  output logic [7:0]  div_d,
  input  logic [7:0]  div_q,
  input  logic [7:0]  div_r,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_q,
  output logic [7:0]  rsp_r,
  output logic        rsp_id,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_id_q, last_id_d;
  logic [15:0] div_n_q, div_n_d;
  logic [7:0]  div_d_q, div_d_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_q_q, rsp_q_d;
  logic [7:0]  rsp_r_q, rsp_r_d;
  logic        rsp_id_q, rsp_id_d;
  logic        rsp_err_q, rsp_err_d;

  logic        grant_valid;
  logic        grant;
  logic        accept;
  logic [15:0] sel_n;
  logic [7:0]  sel_d;
  logic        ovf;

  // Round-robin: on a tie the port that was not served last wins.
  always_comb begin
    grant_valid = 1'b0;
    grant       = 1'b0;
    if (state_q == IDLE && rst_n) begin
      if (req0_valid && req1_valid) begin
        grant_valid = 1'b1;
        grant       = ~last_id_q;
      end else if (req0_valid) begin
        grant_valid = 1'b1;
        grant       = 1'b0;
      end else if (req1_valid) begin
        grant_valid = 1'b1;
        grant       = 1'b1;
      end
    end
  end

  assign req0_ready = grant_valid && !grant;
  assign req1_ready = grant_valid && grant;
  assign accept     = grant_valid;
  assign sel_n      = grant ? req1_n : req0_n;
  assign sel_d      = grant ? req1_d : req0_d;

`ifdef DIV_OVF_CHECK_EN
  // Quotient cannot fit in 8 bits when the upper dividend byte reaches the divisor.
  assign ovf = (sel_d == 8'd0) || (sel_n[15:8] >= sel_d);
`else
  assign ovf = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_id_d   = last_id_q;
    div_n_d     = div_n_q;
    div_d_d     = div_d_q;
    rsp_valid_d = rsp_valid_q;
    rsp_q_d     = rsp_q_q;
    rsp_r_d     = rsp_r_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          div_n_d   = sel_n;
          div_d_d   = sel_d;
          rsp_id_d  = grant;
          last_id_d = grant;
          cnt_d     = CNT_INIT;
          if (ovf) begin
            rsp_q_d     = 8'hFF;
            rsp_r_d     = 8'hFF;
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rsp_q_d     = div_q;
          rsp_r_d     = div_r;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      last_id_q   <= 1'b1;
      div_n_q     <= 16'd0;
      div_d_q     <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_q_q     <= 8'd0;
      rsp_r_q     <= 8'd0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_id_q   <= last_id_d;
      div_n_q     <= div_n_d;
      div_d_q     <= div_d_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q_q     <= rsp_q_d;
      rsp_r_q     <= rsp_r_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign div_n     = div_n_q;
  assign div_d     = div_d_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_q     = rsp_q_q;
  assign rsp_r     = rsp_r_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE);

`ifndef SYNTHESIS
  a_ready_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(req0_ready && req1_ready));
  a_div_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != IDLE) |=> (state_q == IDLE || $stable(div_n_q) && $stable(div_d_q)));
`endif

endmodule
